// File: rtl/ahb_mem_arbiter.sv
// ahb_mem_arbiter: arbitrates an instruction port (0) and a data port (1)
// onto one single-port AHB3-Lite memory. Each port has one pending slot.
// At most one subordinate transfer is in flight. Conflicts are resolved
// round-robin. The data phase passes straight through to the granted port.
module ahb_mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              s_clk_i,
    input  logic              s_resetn_i,
    input  logic              s_hsel_i   [2],
    input  logic [ADDR_W-1:0] s_haddr_i  [2],
    input  logic [1:0]        s_htrans_i [2],
    input  logic              s_hwrite_i [2],
    input  logic [2:0]        s_hsize_i  [2],
    input  logic [31:0]       s_hwdata_i [2],
    output logic [31:0]       s_hrdata_o [2],
    output logic              s_hready_o [2],
    output logic              s_hresp_o  [2],
    output logic              s_m_hsel_o,
    output logic [ADDR_W-1:0] s_m_haddr_o,
    output logic [1:0]        s_m_htrans_o,
    output logic              s_m_hwrite_o,
    output logic [2:0]        s_m_hsize_o,
    output logic [31:0]       s_m_hwdata_o,
    input  logic [31:0]       s_m_hrdata_i,
    input  logic              s_m_hready_i,
    input  logic              s_m_hresp_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    state_t            state_r, state_nx_s;
    logic              grant_r, grant_nx_s;
    logic              last_r, last_nx_s;
    logic [1:0]        pend_r, pend_nx_s;
    logic [1:0]        cap_s, req_s, clr_s;
    logic              done_s, arb_s;
    logic [ADDR_W-1:0] haddr_r  [2];
    logic              hwrite_r [2];
    logic [2:0]        hsize_r  [2];

    // htrans[0] only separates IDLE/BUSY and NONSEQ/SEQ, which are treated alike
    logic unused_s;
    assign unused_s = ^{s_htrans_i[0][0], s_htrans_i[1][0]};

    // A port request is captured when it is selected, active (NONSEQ/SEQ) and its hready is high
    always_comb begin
        cap_s = 2'b00;
        for (int p = 0; p < 2; p++) begin
            cap_s[p] = s_hsel_i[p] & s_htrans_i[p][1] & s_hready_o[p];
        end
    end

    // Pending bookkeeping: completion clears the granted slot; a same-cycle capture re-arms it
    always_comb begin
        req_s  = pend_r | cap_s;
        done_s = (state_r == ST_DATA) & s_m_hready_i;
        if (done_s) begin
            clr_s = grant_r ? 2'b10 : 2'b01;
        end else begin
            clr_s = 2'b00;
        end
        if (req_s == 2'b11) begin
            arb_s = ~last_r;
        end else begin
            arb_s = req_s[1];
        end
        pend_nx_s = (pend_r & ~clr_s) | cap_s;
    end

    // FSM next state, grant and round-robin history
    always_comb begin
        state_nx_s = state_r;
        grant_nx_s = grant_r;
        last_nx_s  = last_r;
        case (state_r)
            ST_IDLE: begin
                if (|req_s) begin
                    state_nx_s = ST_ADDR;
                    grant_nx_s = arb_s;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                state_nx_s = ST_DATA;
            end
            ST_DATA: begin
                if (s_m_hready_i) begin
                    last_nx_s = grant_r;
                    if (req_s[~grant_r]) begin
                        state_nx_s = ST_ADDR;
                        grant_nx_s = ~grant_r;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Control state registers; reset aborts any transfer and drops pending requests
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state_r <= ST_IDLE;
            grant_r <= 1'b0;
            last_r  <= 1'b1;
            pend_r  <= 2'b00;
        end else begin
            state_r <= state_nx_s;
            grant_r <= grant_nx_s;
            last_r  <= last_nx_s;
            pend_r  <= pend_nx_s;
        end
    end

    // Address-phase payload of each pending slot, loaded on capture
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            for (int p = 0; p < 2; p++) begin
                haddr_r[p]  <= {ADDR_W{1'b0}};
                hwrite_r[p] <= 1'b0;
                hsize_r[p]  <= 3'b000;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (cap_s[p]) begin
                    haddr_r[p]  <= s_haddr_i[p];
                    hwrite_r[p] <= s_hwrite_i[p];
                    hsize_r[p]  <= s_hsize_i[p];
                end
            end
        end
    end

    // Manager responses: pass-through for the granted port in DATA, else stall while pending
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            if ((state_r == ST_DATA) && (grant_r == 1'(p))) begin
                s_hrdata_o[p] = s_m_hrdata_i;
                s_hready_o[p] = s_m_hready_i;
                s_hresp_o[p]  = s_m_hresp_i;
            end else begin
                s_hrdata_o[p] = 32'h0000_0000;
                s_hready_o[p] = ~pend_r[p];
                s_hresp_o[p]  = 1'b0;
            end
        end
    end

    // Subordinate request: address phase in ADDR, write data in DATA, quiet otherwise
    always_comb begin
        s_m_hsel_o   = 1'b0;
        s_m_haddr_o  = {ADDR_W{1'b0}};
        s_m_htrans_o = 2'b00;
        s_m_hwrite_o = 1'b0;
        s_m_hsize_o  = 3'b000;
        s_m_hwdata_o = 32'h0000_0000;
        if (state_r == ST_ADDR) begin
            s_m_hsel_o   = 1'b1;
            s_m_htrans_o = 2'b10;
            s_m_haddr_o  = haddr_r[grant_r];
            s_m_hwrite_o = hwrite_r[grant_r];
            s_m_hsize_o  = hsize_r[grant_r];
        end else if (state_r == ST_DATA) begin
            s_m_hwdata_o = s_hwdata_i[grant_r];
        end else begin
            s_m_hwdata_o = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Directed bench for ahb_mem_arbiter: reset values, single read, conflict
// ordering, round-robin fairness, wait/error response, async reset mid-DATA.
module tb_ahb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel   [2];
    logic [31:0] haddr  [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic [2:0]  hsize  [2];
    logic [31:0] hwdata [2];
    logic [31:0] hrdata [2];
    logic        hready [2];
    logic        hresp  [2];
    logic        m_hsel;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic        m_hwrite;
    logic [2:0]  m_hsize;
    logic [31:0] m_hwdata;
    logic [31:0] m_hrdata;
    logic        m_hready;
    logic        m_hresp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ahb_mem_arbiter #(.ADDR_W(32)) dut (
        .s_clk_i      (clk),
        .s_resetn_i   (rst_n),
        .s_hsel_i     (hsel),
        .s_haddr_i    (haddr),
        .s_htrans_i   (htrans),
        .s_hwrite_i   (hwrite),
        .s_hsize_i    (hsize),
        .s_hwdata_i   (hwdata),
        .s_hrdata_o   (hrdata),
        .s_hready_o   (hready),
        .s_hresp_o    (hresp),
        .s_m_hsel_o   (m_hsel),
        .s_m_haddr_o  (m_haddr),
        .s_m_htrans_o (m_htrans),
        .s_m_hwrite_o (m_hwrite),
        .s_m_hsize_o  (m_hsize),
        .s_m_hwdata_o (m_hwdata),
        .s_m_hrdata_i (m_hrdata),
        .s_m_hready_i (m_hready),
        .s_m_hresp_i  (m_hresp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge (input drive point)
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // move to the falling edge (sample point)
    task automatic mid();
        #4;
    endtask

    task automatic req(input int p, input logic [1:0] tr, input logic [31:0] a, input logic w);
        hsel[p]   = 1'b1;
        htrans[p] = tr;
        haddr[p]  = a;
        hwrite[p] = w;
        hsize[p]  = 3'b010;
    endtask

    task automatic drop(input int p);
        hsel[p]   = 1'b0;
        htrans[p] = 2'b00;
    endtask

    task automatic slv(input logic rdy, input logic rsp, input logic [31:0] rd);
        m_hready = rdy;
        m_hresp  = rsp;
        m_hrdata = rd;
    endtask

    initial begin
        int g;
        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            hsel[p]   = 1'b0;
            haddr[p]  = 32'h0;
            htrans[p] = 2'b00;
            hwrite[p] = 1'b0;
            hsize[p]  = 3'b000;
            hwdata[p] = 32'h0;
        end
        slv(1'b1, 1'b0, 32'h1234_5678);

        // ---------------- reset values ----------------
        nxt(); nxt(); mid();
        chk("rst_hready0", 32'(hready[0]), 32'h1);
        chk("rst_hready1", 32'(hready[1]), 32'h1);
        chk("rst_hresp0",  32'(hresp[0]),  32'h0);
        chk("rst_hresp1",  32'(hresp[1]),  32'h0);
        chk("rst_hrdata0", hrdata[0], 32'h0);
        chk("rst_hrdata1", hrdata[1], 32'h0);
        chk("rst_m_hsel",  32'(m_hsel),   32'h0);
        chk("rst_m_htrans",32'(m_htrans), 32'h0);
        chk("rst_m_haddr", m_haddr,  32'h0);
        chk("rst_m_hwdata",m_hwdata, 32'h0);
        chk("rst_m_hwrite",32'(m_hwrite), 32'h0);
        chk("rst_m_hsize", 32'(m_hsize),  32'h0);
        nxt(); rst_n = 1'b1;

        // ---------------- single read, zero wait ----------------
        nxt();
        req(0, 2'b10, 32'h1000_0040, 1'b0);
        mid();
        chk("rd_cap_hready0", 32'(hready[0]), 32'h1);
        chk("rd_cap_m_hsel",  32'(m_hsel),    32'h0);
        nxt(); drop(0); slv(1'b1, 1'b0, 32'hDEAD_BEEF);
        mid();
        chk("rd_addr_m_hsel",   32'(m_hsel),   32'h1);
        chk("rd_addr_m_htrans", 32'(m_htrans), 32'h2);
        chk("rd_addr_m_haddr",  m_haddr,       32'h1000_0040);
        chk("rd_addr_m_hwrite", 32'(m_hwrite), 32'h0);
        chk("rd_addr_m_hsize",  32'(m_hsize),  32'h2);
        chk("rd_addr_hready0",  32'(hready[0]),32'h0);
        chk("rd_addr_hrdata0",  hrdata[0],     32'h0);
        nxt(); mid();
        chk("rd_data_hrdata0", hrdata[0], 32'hDEAD_BEEF);
        chk("rd_data_hready0", 32'(hready[0]), 32'h1);
        chk("rd_data_hresp0",  32'(hresp[0]),  32'h0);
        chk("rd_data_m_hsel",  32'(m_hsel),    32'h0);
        chk("rd_data_m_htrans",32'(m_htrans),  32'h0);
        nxt(); mid();
        chk("rd_idle_hrdata0", hrdata[0], 32'h0);
        chk("rd_idle_hready0", 32'(hready[0]), 32'h1);
        chk("rd_idle_m_hsel",  32'(m_hsel),    32'h0);

        // ---------------- simultaneous requests after reset ----------------
        nxt(); rst_n = 1'b0;
        nxt(); rst_n = 1'b1;
        nxt();
        req(0, 2'b10, 32'h0000_0100, 1'b0);
        req(1, 2'b10, 32'h0000_0200, 1'b1);
        hwdata[0] = 32'h0;
        mid();
        chk("sim_cap_hready0", 32'(hready[0]), 32'h1);
        chk("sim_cap_hready1", 32'(hready[1]), 32'h1);
        nxt(); drop(0); drop(1); hwdata[1] = 32'hA5A5_A5A5; slv(1'b1, 1'b0, 32'h1111_1111);
        mid();
        chk("sim_a0_m_haddr",  m_haddr,       32'h0000_0100);
        chk("sim_a0_m_hwrite", 32'(m_hwrite), 32'h0);
        chk("sim_a0_hready0",  32'(hready[0]),32'h0);
        chk("sim_a0_hready1",  32'(hready[1]),32'h0);
        nxt(); mid();
        chk("sim_d0_hrdata0",  hrdata[0],     32'h1111_1111);
        chk("sim_d0_hready0",  32'(hready[0]),32'h1);
        chk("sim_d0_hready1",  32'(hready[1]),32'h0);
        chk("sim_d0_m_hwdata", m_hwdata,      32'h0);
        nxt(); mid();
        chk("sim_a1_m_hsel",   32'(m_hsel),   32'h1);
        chk("sim_a1_m_haddr",  m_haddr,       32'h0000_0200);
        chk("sim_a1_m_hwrite", 32'(m_hwrite), 32'h1);
        chk("sim_a1_hready1",  32'(hready[1]),32'h0);
        chk("sim_a1_hready0",  32'(hready[0]),32'h1);
        nxt(); mid();
        chk("sim_d1_m_hwdata", m_hwdata,      32'hA5A5_A5A5);
        chk("sim_d1_hready1",  32'(hready[1]),32'h1);
        chk("sim_d1_m_hsel",   32'(m_hsel),   32'h0);
        nxt(); mid();
        chk("sim_idle_m_hwdata", m_hwdata,    32'h0);
        chk("sim_idle_m_hsel",   32'(m_hsel), 32'h0);

        // ---------------- fairness: 20 back-to-back transfers ----------------
        nxt();
        req(0, 2'b10, 32'h0000_1000, 1'b0);
        req(1, 2'b11, 32'h0000_2000, 1'b0);
        nxt();
        for (int i = 0; i < 20; i++) begin
            g = i % 2;
            mid();
            chk("rr_addr_m_hsel", 32'(m_hsel), 32'h1);
            chk("rr_addr_m_haddr", m_haddr, (g == 1) ? 32'h0000_2000 : 32'h0000_1000);
            nxt();
            if (i >= 18) drop(g);
            mid();
            chk("rr_data_hready_own", 32'(hready[g]), 32'h1);
            if (i < 19) chk("rr_data_hready_other", 32'(hready[1 - g]), 32'h0);
            nxt();
        end
        mid();
        chk("rr_end_m_hsel", 32'(m_hsel), 32'h0);

        // ---------------- 3 wait states then two-cycle ERROR ----------------
        nxt();
        req(1, 2'b10, 32'h0000_0300, 1'b0);
        mid();
        nxt(); drop(1); slv(1'b0, 1'b0, 32'h0);
        mid();
        chk("err_addr_m_haddr", m_haddr, 32'h0000_0300);
        chk("err_addr_hready1", 32'(hready[1]), 32'h0);
        for (int k = 0; k < 3; k++) begin
            nxt(); mid();
            chk("err_wait_hready1", 32'(hready[1]), 32'h0);
            chk("err_wait_hresp1",  32'(hresp[1]),  32'h0);
        end
        nxt(); slv(1'b0, 1'b1, 32'h0); mid();
        chk("err1_hready1", 32'(hready[1]), 32'h0);
        chk("err1_hresp1",  32'(hresp[1]),  32'h1);
        nxt(); slv(1'b1, 1'b1, 32'h0); mid();
        chk("err2_hready1", 32'(hready[1]), 32'h1);
        chk("err2_hresp1",  32'(hresp[1]),  32'h1);
        // idle: junk subordinate response and a BUSY beat must both be ignored
        nxt(); slv(1'b0, 1'b1, 32'hFFFF_FFFF); req(0, 2'b01, 32'h0000_0400, 1'b0);
        mid();
        chk("idle_hresp1",  32'(hresp[1]),  32'h0);
        chk("idle_hready1", 32'(hready[1]), 32'h1);
        chk("idle_hresp0",  32'(hresp[0]),  32'h0);
        chk("idle_hready0", 32'(hready[0]), 32'h1);
        chk("idle_hrdata0", hrdata[0],      32'h0);
        nxt(); slv(1'b1, 1'b0, 32'h0); req(0, 2'b10, 32'h0000_0400, 1'b0);
        mid();
        chk("busy_ignored_m_hsel", 32'(m_hsel), 32'h0);
        nxt(); drop(0); mid();
        chk("post_err_m_hsel",  32'(m_hsel), 32'h1);
        chk("post_err_m_haddr", m_haddr,     32'h0000_0400);
        nxt(); slv(1'b1, 1'b0, 32'h7777_7777); mid();
        chk("post_err_hrdata0", hrdata[0],      32'h7777_7777);
        chk("post_err_hready0", 32'(hready[0]), 32'h1);

        // ---------------- asynchronous reset during port 1 DATA ----------------
        nxt();
        req(1, 2'b10, 32'h0000_0500, 1'b1);
        mid();
        nxt(); drop(1); hwdata[1] = 32'hCAFE_F00D; slv(1'b0, 1'b0, 32'h55AA_55AA);
        mid();
        chk("rstd_addr_m_haddr", m_haddr, 32'h0000_0500);
        nxt(); mid();
        chk("rstd_data_m_hwdata", m_hwdata,      32'hCAFE_F00D);
        chk("rstd_data_hrdata1",  hrdata[1],     32'h55AA_55AA);
        chk("rstd_data_hready1",  32'(hready[1]),32'h0);
        #2; rst_n = 1'b0; #1;
        chk("rstd_async_hready1",  32'(hready[1]),  32'h1);
        chk("rstd_async_hrdata1",  hrdata[1],       32'h0);
        chk("rstd_async_hresp1",   32'(hresp[1]),   32'h0);
        chk("rstd_async_m_hwdata", m_hwdata,        32'h0);
        chk("rstd_async_m_hsel",   32'(m_hsel),     32'h0);
        chk("rstd_async_m_htrans", 32'(m_htrans),   32'h0);
        nxt(); nxt(); rst_n = 1'b1; slv(1'b1, 1'b0, 32'h0);
        nxt();
        req(0, 2'b10, 32'h0000_0600, 1'b0);
        mid();
        chk("rstd_rel_hready1", 32'(hready[1]), 32'h1);
        chk("rstd_rel_hready0", 32'(hready[0]), 32'h1);
        nxt(); drop(0); mid();
        chk("rstd_p0_m_hsel",  32'(m_hsel), 32'h1);
        chk("rstd_p0_m_haddr", m_haddr,     32'h0000_0600);
        nxt(); slv(1'b1, 1'b0, 32'h0BAD_F00D); mid();
        chk("rstd_p0_hready0", 32'(hready[0]), 32'h1);
        chk("rstd_p0_hrdata0", hrdata[0],      32'h0BAD_F00D);
        nxt(); mid();
        chk("rstd_end_m_hsel",  32'(m_hsel),    32'h0);
        chk("rstd_end_hready1", 32'(hready[1]), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
